// File: rtl/bist_pkg.sv
// Shared definitions for the March-test BIST engine: mode codes, FSM states
// and the March element table.
package bist_pkg;

    // Algorithm / background select codes
    localparam logic [1:0] MODE_MATS   = 2'b00;
    localparam logic [1:0] MODE_MARCHC = 2'b01;
    localparam logic [1:0] MODE_CKBD   = 2'b10;

    // Sequencer states
    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_RUN   = 2'd1;
    localparam logic [1:0] ST_DRAIN = 2'd2;
    localparam logic [1:0] ST_DONE  = 2'd3;

    // One March element. Bit i of is_write/inv describes op i of the element;
    // inv=1 means the op writes (or expects) the inverted background.
    typedef struct packed {
        logic       down;
        logic       two_ops;
        logic [1:0] is_write;
        logic [1:0] inv;
        logic       last;
    } march_elem_t;

    // Element table for MATS+ (march_c=0) and March C- (march_c=1)
    function automatic march_elem_t elem_lookup(input logic march_c, input logic [2:0] idx);
        march_elem_t e;
        e = '{1'b0, 1'b0, 2'b00, 2'b00, 1'b1};
        if (!march_c) begin
            case (idx)
                3'd0:    e = '{1'b0, 1'b0, 2'b01, 2'b00, 1'b0}; // up(w0)
                3'd1:    e = '{1'b0, 1'b1, 2'b10, 2'b10, 1'b0}; // up(r0,w1)
                3'd2:    e = '{1'b1, 1'b1, 2'b10, 2'b01, 1'b1}; // dn(r1,w0)
                default: e = '{1'b0, 1'b0, 2'b00, 2'b00, 1'b1};
            endcase
        end else begin
            case (idx)
                3'd0:    e = '{1'b0, 1'b0, 2'b01, 2'b00, 1'b0}; // up(w0)
                3'd1:    e = '{1'b0, 1'b1, 2'b10, 2'b10, 1'b0}; // up(r0,w1)
                3'd2:    e = '{1'b0, 1'b1, 2'b10, 2'b01, 1'b0}; // up(r1,w0)
                3'd3:    e = '{1'b1, 1'b1, 2'b10, 2'b10, 1'b0}; // dn(r0,w1)
                3'd4:    e = '{1'b1, 1'b1, 2'b10, 2'b01, 1'b0}; // dn(r1,w0)
                3'd5:    e = '{1'b0, 1'b0, 2'b00, 2'b00, 1'b1}; // up(r0)
                default: e = '{1'b0, 1'b0, 2'b00, 2'b00, 1'b1};
            endcase
        end
        return e;
    endfunction

    // Direction of an element, used to pick its starting address
    function automatic logic elem_is_down(input logic march_c, input logic [2:0] idx);
        march_elem_t e;
        e = elem_lookup(march_c, idx);
        return e.down;
    endfunction

endpackage

// File: rtl/bist_fail_log.sv
// Read-compare pipeline and failure log: expected data, address and read flag
// are delayed by the memory read latency, then compared against the response.
module bist_fail_log
    import bist_pkg::*;
#(
    parameter int unsigned pADDR_WIDTH = 4,
    parameter int unsigned pDATA_WIDTH = 8,
    parameter int unsigned pRD_LAT     = 1,
    parameter int unsigned pFCNT_WIDTH = 8
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   clear,
    input  logic                   rd_issue,
    input  logic [pADDR_WIDTH-1:0] rd_addr,
    input  logic [pDATA_WIDTH-1:0] rd_exp,
    input  logic [pDATA_WIDTH-1:0] rd_data,
    output logic [pADDR_WIDTH-1:0] fail_addr,
    output logic [pFCNT_WIDTH-1:0] fail_cnt
);

    localparam int unsigned LAST = pRD_LAT - 1;
    localparam logic [pFCNT_WIDTH-1:0] CNT_ONE = {{(pFCNT_WIDTH-1){1'b0}}, 1'b1};

    logic [pRD_LAT-1:0]                  vld_q, vld_d;
    logic [pRD_LAT-1:0][pADDR_WIDTH-1:0] addr_pipe_q, addr_pipe_d;
    logic [pRD_LAT-1:0][pDATA_WIDTH-1:0] exp_pipe_q, exp_pipe_d;
    logic [pADDR_WIDTH-1:0]              fail_addr_q, fail_addr_d;
    logic [pFCNT_WIDTH-1:0]              fail_cnt_q, fail_cnt_d;
    logic                                miscompare;

    assign miscompare = vld_q[LAST] && (rd_data != exp_pipe_q[LAST]);

    // Shift the compare pipeline; a clear drops any reads still in flight
    always_comb begin
        vld_d       = vld_q;
        addr_pipe_d = addr_pipe_q;
        exp_pipe_d  = exp_pipe_q;
        vld_d[0]       = rd_issue;
        addr_pipe_d[0] = rd_addr;
        exp_pipe_d[0]  = rd_exp;
        for (int i = 1; i < int'(pRD_LAT); i++) begin
            vld_d[i]       = vld_q[i-1];
            addr_pipe_d[i] = addr_pipe_q[i-1];
            exp_pipe_d[i]  = exp_pipe_q[i-1];
        end
        if (clear) begin
            vld_d = '0;
        end
    end

    // First-fail address and saturating miscompare count
    always_comb begin
        fail_addr_d = fail_addr_q;
        fail_cnt_d  = fail_cnt_q;
        if (clear) begin
            fail_addr_d = '0;
            fail_cnt_d  = '0;
        end else if (miscompare) begin
            if (fail_cnt_q == '0) begin
                fail_addr_d = addr_pipe_q[LAST];
            end
            if (fail_cnt_q != '1) begin
                fail_cnt_d = fail_cnt_q + CNT_ONE;
            end
        end
    end

    // Pipeline and log registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_q       <= '0;
            addr_pipe_q <= '0;
            exp_pipe_q  <= '0;
            fail_addr_q <= '0;
            fail_cnt_q  <= '0;
        end else begin
            vld_q       <= vld_d;
            addr_pipe_q <= addr_pipe_d;
            exp_pipe_q  <= exp_pipe_d;
            fail_addr_q <= fail_addr_d;
            fail_cnt_q  <= fail_cnt_d;
        end
    end

    assign fail_addr = fail_addr_q;
    assign fail_cnt  = fail_cnt_q;

endmodule

// File: rtl/bist_march_engine.sv
// March-test MBIST engine: sequences MATS+ or March C- over one SRAM port with
// solid or checkerboard background and logs miscompares via bist_fail_log.
module bist_march_engine
    import bist_pkg::*;
#(
    parameter int unsigned pADDR_WIDTH = 4,
    parameter int unsigned pDATA_WIDTH = 8,
    parameter int unsigned pRD_LAT     = 1,
    parameter int unsigned pFCNT_WIDTH = 8
) (
    input  logic                   bist_clk,
    input  logic                   bist_rst_n,
    input  logic                   bist_start,
    input  logic                   bist_abort,
    input  logic [1:0]             bist_mode,
    input  logic [pDATA_WIDTH-1:0] bist_resp,
    output logic                   bist_cs,
    output logic                   bist_we,
    output logic [pADDR_WIDTH-1:0] bist_addr,
    output logic [pDATA_WIDTH-1:0] bist_pat,
    output logic                   bist_busy,
    output logic                   bist_done,
    output logic                   pass_or_fail,
    output logic [pADDR_WIDTH-1:0] fail_addr,
    output logic [pFCNT_WIDTH-1:0] fail_cnt
);

    localparam logic [pADDR_WIDTH-1:0] ADDR_ONE   = {{(pADDR_WIDTH-1){1'b0}}, 1'b1};
    localparam logic [2:0]             DRAIN_LAST = 3'(pRD_LAT);

    logic [1:0]             state_q, state_d;
    logic [1:0]             mode_q, mode_d;
    logic [2:0]             elem_q, elem_d;
    logic                   op_q, op_d;
    logic [pADDR_WIDTH-1:0] addr_q, addr_d;
    logic [2:0]             drain_q, drain_d;

    march_elem_t            cur_elem;
    logic                   march_c;
    logic                   run;
    logic                   start_ok;
    logic                   op_we;
    logic                   last_op;
    logic                   addr_end;
    logic [pDATA_WIDTH-1:0] ckbd_even;
    logic [pDATA_WIDTH-1:0] background;
    logic [pDATA_WIDTH-1:0] op_data;

    assign march_c  = (mode_q != MODE_MATS);
    assign cur_elem = elem_lookup(march_c, elem_q);
    assign run      = (state_q == ST_RUN);
    assign start_ok = bist_start && ((state_q == ST_IDLE) || (state_q == ST_DONE));
    assign op_we    = cur_elem.is_write[op_q];
    assign last_op  = !cur_elem.two_ops || op_q;
    assign addr_end = cur_elem.down ? (addr_q == '0) : (addr_q == '1);

    // Background word for the current address, then the op's data polarity
    always_comb begin
        ckbd_even = '0;
        for (int i = 0; i < int'(pDATA_WIDTH); i++) begin
            ckbd_even[i] = (i % 2 == 0);
        end
        if (mode_q == MODE_CKBD) begin
            background = addr_q[0] ? ~ckbd_even : ckbd_even;
        end else begin
            background = '0;
        end
        op_data = cur_elem.inv[op_q] ? ~background : background;
    end

    // Sequencer next state: op within element, address step, element step, drain
    always_comb begin
        state_d = state_q;
        mode_d  = mode_q;
        elem_d  = elem_q;
        op_d    = op_q;
        addr_d  = addr_q;
        drain_d = drain_q;
        if (bist_abort) begin
            state_d = ST_IDLE;
        end else begin
            case (state_q)
                ST_IDLE, ST_DONE: begin
                    if (bist_start) begin
                        state_d = ST_RUN;
                        mode_d  = bist_mode;
                        elem_d  = '0;
                        op_d    = 1'b0;
                        addr_d  = elem_is_down(bist_mode != MODE_MATS, 3'd0) ? '1 : '0;
                    end
                end
                ST_RUN: begin
                    if (!last_op) begin
                        op_d = 1'b1;
                    end else begin
                        op_d = 1'b0;
                        if (!addr_end) begin
                            addr_d = cur_elem.down ? addr_q - ADDR_ONE : addr_q + ADDR_ONE;
                        end else if (cur_elem.last) begin
                            state_d = ST_DRAIN;
                            drain_d = '0;
                        end else begin
                            elem_d = elem_q + 3'd1;
                            addr_d = elem_is_down(march_c, elem_q + 3'd1) ? '1 : '0;
                        end
                    end
                end
                ST_DRAIN: begin
                    // Hold until the final read has been compared and logged
                    if (drain_q == DRAIN_LAST) begin
                        state_d = ST_DONE;
                    end else begin
                        drain_d = drain_q + 3'd1;
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    // Sequencer registers
    always_ff @(posedge bist_clk or negedge bist_rst_n) begin
        if (!bist_rst_n) begin
            state_q <= ST_IDLE;
            mode_q  <= MODE_MATS;
            elem_q  <= '0;
            op_q    <= 1'b0;
            addr_q  <= '0;
            drain_q <= '0;
        end else begin
            state_q <= state_d;
            mode_q  <= mode_d;
            elem_q  <= elem_d;
            op_q    <= op_d;
            addr_q  <= addr_d;
            drain_q <= drain_d;
        end
    end

    // Memory port and status outputs; the port is quiet outside RUN
    always_comb begin
        bist_cs   = run;
        bist_we   = run && op_we;
        bist_addr = run ? addr_q : '0;
        bist_pat  = run ? op_data : '0;
        bist_busy = (state_q == ST_RUN) || (state_q == ST_DRAIN);
        bist_done = (state_q == ST_DONE);
    end

    bist_fail_log #(
        .pADDR_WIDTH (pADDR_WIDTH),
        .pDATA_WIDTH (pDATA_WIDTH),
        .pRD_LAT     (pRD_LAT),
        .pFCNT_WIDTH (pFCNT_WIDTH)
    ) u_fail_log (
        .clk       (bist_clk),
        .rst_n     (bist_rst_n),
        .clear     (bist_abort || start_ok),
        .rd_issue  (run && !op_we),
        .rd_addr   (addr_q),
        .rd_exp    (op_data),
        .rd_data   (bist_resp),
        .fail_addr (fail_addr),
        .fail_cnt  (fail_cnt)
    );

    assign pass_or_fail = (fail_cnt == '0);

endmodule

// File: tb/tb_bist_march_engine.sv
// Self-checking bench for bist_march_engine: a fault-injectable 16x8 memory,
// a March-notation reference model, directed scenarios and randomized runs.
module tb_bist_march_engine;

    localparam int AW = 4;
    localparam int DW = 8;
    localparam int D  = 16;
    localparam int RL = 1;
    localparam logic [DW-1:0] SAT_RESP = 8'h5A;

    logic          clk = 1'b0;
    logic          rst_n, start, abort;
    logic [1:0]    mode;
    logic [DW-1:0] resp;
    logic          cs, we, busy, done, pass;
    logic [AW-1:0] addr, fail_addr;
    logic [DW-1:0] pat;
    logic [7:0]    fail_cnt;

    logic          cs2, we2, busy2, done2, pass2;
    logic [AW-1:0] addr2, fail_addr2;
    logic [DW-1:0] pat2;
    logic [3:0]    fail_cnt2;

    always #5 clk = ~clk;

    bist_march_engine #(.pADDR_WIDTH(AW), .pDATA_WIDTH(DW), .pRD_LAT(RL), .pFCNT_WIDTH(8)) dut (
        .bist_clk(clk), .bist_rst_n(rst_n), .bist_start(start), .bist_abort(abort),
        .bist_mode(mode), .bist_resp(resp), .bist_cs(cs), .bist_we(we), .bist_addr(addr),
        .bist_pat(pat), .bist_busy(busy), .bist_done(done), .pass_or_fail(pass),
        .fail_addr(fail_addr), .fail_cnt(fail_cnt)
    );

    // Second engine reads a constant word, so every read fails and its 4-bit count saturates
    bist_march_engine #(.pADDR_WIDTH(AW), .pDATA_WIDTH(DW), .pRD_LAT(3), .pFCNT_WIDTH(4)) dut_sat (
        .bist_clk(clk), .bist_rst_n(rst_n), .bist_start(start), .bist_abort(abort),
        .bist_mode(mode), .bist_resp(SAT_RESP), .bist_cs(cs2), .bist_we(we2), .bist_addr(addr2),
        .bist_pat(pat2), .bist_busy(busy2), .bist_done(done2), .pass_or_fail(pass2),
        .fail_addr(fail_addr2), .fail_cnt(fail_cnt2)
    );

    int n_checks = 0;
    int n_errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Fault configuration: 0 none, 1 stuck-at bit, 2 inversion coupling aggr->vict
    int            fkind = 0;
    logic [AW-1:0] f_addr = '0, c_aggr = '0, c_vict = '0;
    int            f_bit = 0;
    logic          f_val = 1'b0;

    logic [DW-1:0] env_mem [D];
    logic [DW-1:0] mdl_mem [D];

    function automatic logic [DW-1:0] faulty(input logic [AW-1:0] a, input logic [DW-1:0] raw);
        logic [DW-1:0] r;
        r = raw;
        if (fkind == 1 && a == f_addr) r[f_bit] = f_val;
        return r;
    endfunction

    // Memory seen by the DUT: one-cycle read latency, faults applied
    always @(posedge clk) begin
        if (cs) begin
            if (we) begin
                if (fkind == 2 && addr == c_aggr && pat != env_mem[addr])
                    env_mem[c_vict] <= ~env_mem[c_vict];
                env_mem[addr] <= pat;
            end else begin
                resp <= faulty(addr, env_mem[addr]);
            end
        end
    end

    // Reference model: expected op stream and expected log contents
    typedef struct {
        logic          we;
        logic [AW-1:0] a;
        logic [DW-1:0] d;
    } op_t;

    op_t           exp_q[$];
    logic [1:0]    cur_mode;
    int            m_cnt, m_reads;
    logic [AW-1:0] m_faddr, m_first_rd;

    function automatic logic [DW-1:0] bg(input int a);
        if (cur_mode == 2'b10) return (a % 2 == 0) ? 8'h55 : 8'hAA;
        return 8'h00;
    endfunction

    task automatic elem(input bit down, input string ops);
        op_t           o;
        logic [DW-1:0] r;
        for (int s = 0; s < D; s++) begin
            int a;
            a = down ? (D - 1 - s) : s;
            for (int i = 0; i < ops.len(); i += 2) begin
                o.we = (ops[i] == "w");
                o.a  = AW'(a);
                o.d  = (ops[i+1] == "1") ? ~bg(a) : bg(a);
                exp_q.push_back(o);
                if (o.we) begin
                    if (fkind == 2 && o.a == c_aggr && o.d != mdl_mem[a])
                        mdl_mem[c_vict] = ~mdl_mem[c_vict];
                    mdl_mem[a] = o.d;
                end else begin
                    if (m_reads == 0) m_first_rd = o.a;
                    m_reads++;
                    r = faulty(o.a, mdl_mem[a]);
                    if (r != o.d) begin
                        if (m_cnt == 0) m_faddr = o.a;
                        m_cnt++;
                    end
                end
            end
        end
    endtask

    task automatic build_model(input logic [1:0] m);
        exp_q.delete();
        cur_mode = m;
        for (int a = 0; a < D; a++) mdl_mem[a] = env_mem[a];
        m_cnt = 0; m_reads = 0; m_faddr = '0; m_first_rd = '0;
        if (m == 2'b00) begin
            elem(0, "w0"); elem(0, "r0w1"); elem(1, "r1w0");
        end else begin
            elem(0, "w0"); elem(0, "r0w1"); elem(0, "r1w0");
            elem(1, "r0w1"); elem(1, "r1w0"); elem(0, "r0");
        end
    endtask

    int            last_seen, last_gap;
    logic [AW-1:0] cap_addr [256];
    logic [DW-1:0] cap_pat  [256];
    logic          cap_we   [256];

    // Start a run and compare the DUT against the model on every cycle until done
    task automatic run_check(input logic [1:0] m, input int ks);
        int k, gap, seen, exp_sat;
        bit finished;
        build_model(m);
        @(negedge clk); start = 1'b1; mode = m;
        @(negedge clk); start = 1'b0;
        k = 0; gap = 0; seen = 0; finished = 0;
        for (int cyc = 0; cyc < 600; cyc++) begin
            if (done) begin finished = 1; break; end
            if (cs) begin seen++; gap = 0; end else gap++;
            if (cyc < 256) begin cap_addr[cyc] = addr; cap_pat[cyc] = pat; cap_we[cyc] = we; end
            if (k < exp_q.size()) begin
                chk($sformatf("op%0d", k), 32'({cs, we, addr, pat, busy, done}),
                    32'({1'b1, exp_q[k].we, exp_q[k].a, exp_q[k].d, 1'b1, 1'b0}));
                k++;
            end else begin
                chk("drain", 32'({cs, busy}), 32'(2'b01));
            end
            if (cyc == ks) start = 1'b1;
            else if (cyc == ks + 1) start = 1'b0;
            @(negedge clk);
        end
        start = 1'b0;
        chk("run_finished", 32'(finished), 32'd1);
        chk("cs_cycles", 32'(seen), 32'(exp_q.size()));
        chk("drain_len", 32'(gap), 32'(RL + 1));
        chk("fail_cnt", 32'(fail_cnt), 32'((m_cnt > 255) ? 255 : m_cnt));
        chk("fail_addr", 32'(fail_addr), 32'(m_faddr));
        chk("pass", 32'(pass), 32'(m_cnt == 0));
        chk("done_idle_port", 32'({busy, cs}), 32'd0);
        last_seen = seen; last_gap = gap;
        for (int w = 0; w < 10 && !done2; w++) @(negedge clk);
        exp_sat = (m_reads > 15) ? 15 : m_reads;
        chk("sat_done", 32'(done2), 32'd1);
        chk("sat_cnt", 32'(fail_cnt2), 32'(exp_sat));
        chk("sat_addr", 32'(fail_addr2), 32'(m_first_rd));
        chk("sat_pass", 32'(pass2), 32'd0);
    endtask

    task automatic chk_idle(input string name);
        chk({name, "_port"}, 32'({cs, we, addr, pat, busy, done}), 32'd0);
        chk({name, "_log"}, 32'({pass, fail_addr, fail_cnt}), 32'({1'b1, 4'd0, 8'd0}));
    endtask

    initial begin
        rst_n = 1'b0; start = 1'b0; abort = 1'b0; mode = 2'b00;
        repeat (2) @(negedge clk);
        chk_idle("reset");
        rst_n = 1'b1;

        // March C-, fault-free
        fkind = 0;
        run_check(2'b01, -1);
        chk("t1_cs_cycles", 32'(last_seen), 32'd160);
        chk("t1_done_gap", 32'(last_gap), 32'd2);
        chk("t1_pass", 32'(pass), 32'd1);

        // MATS+ address order
        run_check(2'b00, -1);
        chk("t2_cs_cycles", 32'(last_seen), 32'd80);
        chk("t2_addr15", 32'(cap_addr[15]), 32'd15);
        chk("t2_addr16", 32'(cap_addr[16]), 32'd0);
        chk("t2_addr47", 32'(cap_addr[47]), 32'd15);
        chk("t2_addr48", 32'(cap_addr[48]), 32'd15);
        chk("t2_addr79", 32'(cap_addr[79]), 32'd0);

        // Stuck-at-1 on bit 0 of address 5
        fkind = 1; f_addr = 4'd5; f_bit = 0; f_val = 1'b1;
        run_check(2'b01, -1);
        chk("t3_cnt", 32'(fail_cnt), 32'd3);
        chk("t3_addr", 32'(fail_addr), 32'd5);
        chk("t3_pass", 32'(pass), 32'd0);

        // Checkerboard background, then coupling 3->4
        fkind = 0;
        run_check(2'b10, -1);
        chk("t4_pat0", 32'({cap_we[0], cap_pat[0]}), 32'h155);
        chk("t4_pat1", 32'({cap_we[1], cap_pat[1]}), 32'h1AA);
        fkind = 2; c_aggr = 4'd3; c_vict = 4'd4;
        run_check(2'b10, -1);
        chk("t4_cnt_nonzero", 32'(fail_cnt != 0), 32'd1);
        chk("t4_addr", 32'(fail_addr), 32'd4);

        // Abort mid-run with a logged failure, then a clean run
        fkind = 1; f_addr = 4'd2; f_bit = 3; f_val = 1'b1;
        @(negedge clk); start = 1'b1; mode = 2'b01;
        @(negedge clk); start = 1'b0;
        repeat (40) @(negedge clk);
        chk("t5_pre_abort_cnt", 32'(fail_cnt != 0), 32'd1);
        abort = 1'b1;
        @(negedge clk); abort = 1'b0;
        chk_idle("t5_abort");
        fkind = 0;
        run_check(2'b01, -1);

        // Asynchronous reset mid-run
        @(negedge clk); start = 1'b1; mode = 2'b01;
        @(negedge clk); start = 1'b0;
        repeat (69) @(negedge clk);
        @(posedge clk); #2 rst_n = 1'b0;
        #1 chk_idle("t6_reset");
        chk("t6_sat_busy", 32'(busy2), 32'd0);
        @(negedge clk); rst_n = 1'b1;

        // Start pulse during RUN must be ignored
        run_check(2'b00, 20);

        // Randomized runs
        for (int it = 0; it < 8; it++) begin
            logic [1:0] m;
            int ks;
            fkind  = $urandom_range(0, 2);
            f_addr = AW'($urandom_range(0, D - 1));
            f_bit  = $urandom_range(0, DW - 1);
            f_val  = 1'($urandom_range(0, 1));
            c_aggr = AW'($urandom_range(0, D - 1));
            c_vict = c_aggr + AW'($urandom_range(1, D - 1));
            m      = 2'($urandom_range(0, 3));
            ks     = ($urandom_range(0, 1) == 1) ? $urandom_range(2, 60) : -1;
            run_check(m, ks);
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
